mult_booth_nr: RTL

MULT_BOOTH_NR -- requirements
Module: mult_booth_nr

---
 rtl/mult_pkg.sv | 19 +
 rtl/reg_desp_n.sv | 27 ++
 rtl/mult_booth_nr.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the Booth multiplier: FSM states, radix encoding and
// the iteration-count helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic RADIX2 = 1'b0;
    localparam logic RADIX4 = 1'b1;

    // Radix-4 consumes two multiplier bits per iteration.
    function automatic int iter_count(input int n, input logic radix4);
        return (radix4 == RADIX4) ? n / 2 : n;
    endfunction

endpackage

// File: rtl/reg_desp_n.sv
// W-bit register with parallel load and a right shift by 1 or 2 positions,
// filling the vacated top bits from shift_in. Load has priority over shift.
module reg_desp_n #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift_en,
    input  logic         shift2,
    input  logic [1:0]   shift_in,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (shift_en) begin
            // A single shift takes only shift_in[0].
            value <= shift2 ? {shift_in, value[W-1:2]} : {shift_in[0], value[W-1:1]};
        end
    end

endmodule

// File: rtl/mult_booth_nr.sv
// Sequential signed multiplier, Booth radix-2 or radix-4 selected per operation.
// Handshake: start is sampled only in IDLE; done pulses one cycle when product is valid.
module mult_booth_nr
    import mult_pkg::*;
#(
    parameter int N = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           radix4,
    input  logic [N-1:0]   m,
    input  logic [N-1:0]   q,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic [1:0]     state_dbg
);

    localparam int AW = N + 2;
    localparam int CW = $clog2(N + 1);

    generate
        if ((N % 2) != 0 || N < 4) begin : g_bad_n
            $error("mult_booth_nr: N must be even and >= 4");
        end
    endgenerate

    state_t        state;
    logic [AW-1:0] m_reg;
    logic [AW-1:0] a_reg;
    logic [AW-1:0] addend;
    logic [AW-1:0] a_sum;
    logic [AW-1:0] a_next;
    logic [AW-1:0] a_load_val;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  q_next;
    logic [CW-1:0] count;
    logic [2:0]    recode;
    logic          q_m1;
    logic          mode;
    logic          sub;
    logic          accept;
    logic          calc;
    logic          a_load;

    assign accept    = (state == IDLE) && start;
    assign calc      = (state == CALC);
    assign state_dbg = state;

    // Booth recoding: pick the magnitude to add and whether to subtract it.
    always_comb begin
        addend = '0;
        sub    = 1'b0;
        recode = {q_reg[1:0], q_m1};
        if (mode == RADIX4) begin
            case (recode)
                3'b001, 3'b010: addend = m_reg;
                3'b011:         addend = m_reg << 1;
                3'b100: begin
                    addend = m_reg << 1;
                    sub    = 1'b1;
                end
                3'b101, 3'b110: begin
                    addend = m_reg;
                    sub    = 1'b1;
                end
                default: addend = '0;
            endcase
        end else begin
            case ({q_reg[0], q_m1})
                2'b01: addend = m_reg;
                2'b10: begin
                    addend = m_reg;
                    sub    = 1'b1;
                end
                default: addend = '0;
            endcase
        end
    end

    assign a_sum = sub ? (a_reg - addend) : (a_reg + addend);

    // Arithmetic right shift of {A,Q,q_-1}; the low bits of the sum move into Q.
    assign a_next = (mode == RADIX4) ? {{2{a_sum[AW-1]}}, a_sum[AW-1:2]}
                                     : {a_sum[AW-1], a_sum[AW-1:1]};
    assign q_next = (mode == RADIX4) ? {a_sum[1:0], q_reg[N-1:2]}
                                     : {a_sum[0], q_reg[N-1:1]};

    assign a_load     = accept | calc;
    assign a_load_val = calc ? a_next : '0;

    reg_desp_n #(.W(AW)) u_a_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (a_load),
        .load_val (a_load_val),
        .shift_en (1'b0),
        .shift2   (1'b0),
        .shift_in (2'b00),
        .value    (a_reg)
    );

    reg_desp_n #(.W(N)) u_q_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (q),
        .shift_en (calc),
        .shift2   (mode),
        .shift_in (a_sum[1:0]),
        .value    (q_reg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            m_reg   <= '0;
            q_m1    <= 1'b0;
            mode    <= RADIX2;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m_reg <= {{2{m[N-1]}}, m};
                        q_m1  <= 1'b0;
                        mode  <= radix4;
                        count <= CW'(iter_count(N, radix4));
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    q_m1  <= (mode == RADIX4) ? q_reg[1] : q_reg[0];
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        product <= {a_next[N-1:0], q_next};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
